// File: rtl/tdc_stream_sequencer_pkg.sv
// Shared types and defaults for the TDC stream sequencer: FSM encoding,
// default geometry and an index-width helper.
package tdc_stream_sequencer_pkg;

  localparam int NP_DEF        = 10;
  localparam int PIXEL_NUM_DEF = 3;
  localparam int ACQ_NUM_DEF   = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Index width for a count of n items; at least one bit so n=1 still has a port.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdc_stream_sequencer_if.sv
// Bundle of the TDC input handshake and the hisBuilderFSM-facing stream.
// master = producer/observer side, slave = the sequencer.
interface tdc_stream_sequencer_if
  import tdc_stream_sequencer_pkg::*;
#(
  parameter int NP        = NP_DEF,
  parameter int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int ACQ_NUM   = ACQ_NUM_DEF
) ();

  localparam int PW = idx_w(PIXEL_NUM);
  localparam int AW = idx_w(ACQ_NUM);

  logic          start;
  logic          in_valid;
  logic [NP-1:0] in_data;
  logic          in_ready;
  logic          wrEn;
  logic [NP-1:0] data;
  logic [PW-1:0] pix_idx;
  logic [AW-1:0] acq_idx;
  logic          busy;
  logic          frame_done;
  logic          underrun;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, wrEn, data, pix_idx, acq_idx, busy, frame_done, underrun
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, wrEn, data, pix_idx, acq_idx, busy, frame_done, underrun
  );

endinterface

// File: rtl/tdc_stream_sequencer_fifo.sv
// Small synchronous FIFO with registered full/empty; head is read combinationally
// so a pop and its data land on the same edge.
module sync_stream_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && !empty_q;
    // Full is judged before this edge's pop, so a push never lands on a full buffer.
    do_push  = push && !full_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
    cnt_d   = cnt_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    full_d  = (cnt_d == (AW + 1)'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/tdc_stream_sequencer.sv
// Buffers TDC timestamps and replays them as the fixed-cadence wrEn/data stream
// for hisBuilderFSM: PIXEL_NUM words per acquisition, ACQ_NUM acquisitions, idle gaps.
module tdc_stream_sequencer
  import tdc_stream_sequencer_pkg::*;
#(
  parameter int NP         = NP_DEF,
  parameter int PIXEL_NUM  = PIXEL_NUM_DEF,
  parameter int ACQ_NUM    = ACQ_NUM_DEF,
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   res,
  tdc_stream_sequencer_if.slave  bus
);

  localparam int PW = idx_w(PIXEL_NUM);
  localparam int AW = idx_w(ACQ_NUM);
  localparam int GW = idx_w(GAP_CYCLES);

  state_t        state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [AW-1:0] acq_cnt_q, acq_cnt_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          wr_q, wr_d;
  logic [NP-1:0] data_q, data_d;
  logic [PW-1:0] pix_idx_q, pix_idx_d;
  logic [AW-1:0] acq_idx_q, acq_idx_d;
  logic          busy_q, busy_d;
  logic          fd_q, fd_d;
  logic          und_q, und_d;

  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [NP-1:0] fifo_head;

  assign bus.in_ready = !fifo_full && !res;
  assign fifo_push    = bus.in_valid && bus.in_ready;

  sync_stream_fifo #(.W(NP), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (res),
    .push  (fifo_push),
    .wdata (bus.in_data),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    acq_cnt_d = acq_cnt_q;
    gap_d     = gap_q;
    wr_d      = 1'b0;
    data_d    = data_q;
    pix_idx_d = pix_idx_q;
    acq_idx_d = acq_idx_q;
    busy_d    = busy_q;
    fd_d      = 1'b0;
    und_d     = und_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // The frame_done cycle is still IDLE; a start landing there is dropped.
        if (bus.start && !fd_q) begin
          state_d   = ST_STREAM;
          pix_cnt_d = '0;
          acq_cnt_d = '0;
          pix_idx_d = '0;
          acq_idx_d = '0;
          busy_d    = 1'b1;
        end
      end
      ST_STREAM: begin
        wr_d      = 1'b1;
        pix_idx_d = pix_cnt_q;
        acq_idx_d = acq_cnt_q;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
        end else begin
          data_d = '1;
          und_d  = 1'b1;
        end
        if (pix_cnt_q == PW'(PIXEL_NUM - 1)) begin
          pix_cnt_d = '0;
          if (acq_cnt_q == AW'(ACQ_NUM - 1)) begin
            state_d = ST_DONE;
          end else begin
            acq_cnt_d = acq_cnt_q + AW'(1);
            gap_d     = '0;
            state_d   = (GAP_CYCLES == 0) ? ST_STREAM : ST_GAP;
          end
        end else begin
          pix_cnt_d = pix_cnt_q + PW'(1);
        end
      end
      ST_GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) state_d = ST_STREAM;
        else                              gap_d   = gap_q + GW'(1);
      end
      ST_DONE: begin
        fd_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      acq_cnt_q <= '0;
      gap_q     <= '0;
      wr_q      <= 1'b0;
      data_q    <= '0;
      pix_idx_q <= '0;
      acq_idx_q <= '0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      acq_cnt_q <= acq_cnt_d;
      gap_q     <= gap_d;
      wr_q      <= wr_d;
      data_q    <= data_d;
      pix_idx_q <= pix_idx_d;
      acq_idx_q <= acq_idx_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
      und_q     <= und_d;
    end
  end

  assign bus.wrEn       = wr_q;
  assign bus.data       = data_q;
  assign bus.pix_idx    = pix_idx_q;
  assign bus.acq_idx    = acq_idx_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = fd_q;
  assign bus.underrun   = und_q;

endmodule
